// File: rtl/uart_pkg.sv
// Shared UART receive types and default frame parameters.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_tick_counter.sv
// Oversample tick counter: counts sample_tick within a bit period and flags the
// mid-bit and last-tick positions, qualified by the tick itself.
module uart_rx_tick_counter
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_tick,
  input  logic clear,
  output logic mid_bit_c,
  output logic full_bit_c
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);

  logic [CW-1:0] tick_cnt;

  // Clear has priority so the FSM can restart a bit period on the sampling tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (clear) begin
      tick_cnt <= '0;
    end else if (sample_tick) begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  assign mid_bit_c  = sample_tick && (tick_cnt == CW'(OVERSAMPLE / 2 - 1));
  assign full_bit_c = sample_tick && (tick_cnt == CW'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_rx_shift_register.sv
// UART receiver: synchroniser, start detect, mid-bit sampling, LSB-first shift, stop check.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_shift_register
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  rx_state_t            state, state_next;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [DATA_BITS-1:0] shift_reg;
  logic [BW-1:0]        bit_cnt;
  logic                 cnt_clear, shift_en, load, ferr;
  logic                 mid_bit, full_bit;
`ifdef UART_RX_PARITY_EN
  logic                 par_capture, par_bad;
`endif

  uart_rx_tick_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .clear       (cnt_clear),
    .mid_bit_c   (mid_bit),
    .full_bit_c  (full_bit)
  );

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    shift_en   = 1'b0;
    load       = 1'b0;
    ferr       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_capture = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        if (!rx_sync && rx_prev) begin
          state_next = START;
        end
      end
      START: begin
        if (mid_bit) begin
          cnt_clear  = 1'b1;
          state_next = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (full_bit) begin
          cnt_clear = 1'b1;
          shift_en  = 1'b1;
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (full_bit) begin
          cnt_clear   = 1'b1;
          par_capture = 1'b1;
          state_next  = STOP;
        end
      end
`else
      PARITY: state_next = IDLE;
`endif
      STOP: begin
        if (full_bit) begin
          cnt_clear  = 1'b1;
          load       = rx_sync;
          ferr       = !rx_sync;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (shift_en) begin
        shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
      end
      if (load) begin
        data_out <= shift_reg;
      end
      data_valid  <= load;
      framing_err <= ferr;
      busy        <= (state_next != IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Mismatch against even parity, reported only alongside a good stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_capture) begin
        par_bad <= rx_sync ^ (^shift_reg);
      end
      parity_err <= load && par_bad;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_shift_register.sv
// Directed table-driven bench for uart_rx_shift_register with sample_tick held high.
// Covers parity frames too when UART_RX_PARITY_EN is defined.
module tb_uart_rx_shift_register;

  localparam int unsigned OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam int LAT = int'(OS * FRAME_BITS) - 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_tick;
  logic       rx_serial;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_shift_register #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .rx_serial   (rx_serial),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .framing_err (framing_err),
`ifdef UART_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dv_cnt   = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;
  int dv_cyc   = 0;
  int bit_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt = dv_cnt + 1;
      dv_cyc = cyc;
    end
    if (framing_err) fe_cnt = fe_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt = pe_cnt + 1;
`endif
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_dv;
    int         exp_fe;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx_serial = b;
    bit_cyc   = cyc;
    repeat (OS - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, output int start_cyc);
    send_bit(1'b0);
    start_cyc = bit_cyc;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) rx_serial = 1'b0;
`endif
    send_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    @(negedge clk);
    rx_serial = 1'b1;
    repeat (n * int'(OS)) @(negedge clk);
  endtask

  initial begin
    int dv0, fe0, pe0, st, st2;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h5A, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[5] = '{8'h7E, 1'b0, 0, 1, 8'h81};
    vecs[6] = '{8'h3C, 1'b1, 1, 0, 8'h3C};

    rst_n       = 1'b0;
    sample_tick = 1'b1;
    rx_serial   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset data_out", int'(data_out), 0);
    check("reset data_valid", int'(data_valid), 0);
    check("reset framing_err", int'(framing_err), 0);
    check("reset busy", int'(busy), 0);
    rst_n = 1'b1;
    idle_bits(1);

    for (int i = 0; i < 7; i++) begin
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_frame(vecs[i].data, ^vecs[i].data, vecs[i].stop, st);
      idle_bits(2);
      check($sformatf("vec%0d data_valid pulses", i), dv_cnt - dv0, vecs[i].exp_dv);
      check($sformatf("vec%0d framing_err pulses", i), fe_cnt - fe0, vecs[i].exp_fe);
      check($sformatf("vec%0d data_out", i), int'(data_out), int'(vecs[i].exp_out));
      check($sformatf("vec%0d busy idle", i), int'(busy), 0);
      if (vecs[i].exp_dv == 1) check($sformatf("vec%0d latency", i), dv_cyc - st, LAT);
    end

    // False start: 4 ticks low, then high.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    check("false start busy", int'(busy), 1);
    rx_serial = 1'b1;
    repeat (2 * OS) @(negedge clk);
    check("false start data_valid", dv_cnt - dv0, 0);
    check("false start framing_err", fe_cnt - fe0, 0);
    check("false start busy after", int'(busy), 0);

    // Back-to-back 0x00 then 0xFF, no idle gap.
    dv0 = dv_cnt;
    send_frame(8'h00, 1'b0, 1'b1, st);
    check("b2b first data_out", int'(data_out), 8'h00);
    send_frame(8'hFF, 1'b0, 1'b1, st2);
    idle_bits(1);
    check("b2b data_valid pulses", dv_cnt - dv0, 2);
    check("b2b second data_out", int'(data_out), 8'hFF);
    check("b2b second latency", dv_cyc - st2, LAT);

    // Break: framing error then line held low must not restart.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h00, 1'b0, 1'b0, st);
    repeat (3 * OS) @(negedge clk);
    check("break framing_err", fe_cnt - fe0, 1);
    check("break busy while low", int'(busy), 0);
    idle_bits(1);
    check("break data_valid", dv_cnt - dv0, 0);
    check("break data_out kept", int'(data_out), 8'hFF);

    // Reset in the middle of 0x3C's data bits.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n     = 1'b0;
    rx_serial = 1'b1;
    repeat (4) @(negedge clk);
    check("midreset data_out", int'(data_out), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset data_valid", int'(data_valid), 0);
    rst_n = 1'b1;
    idle_bits(11);
    check("midreset no pulses", (dv_cnt - dv0) + (fe_cnt - fe0), 0);
    send_frame(8'h3C, 1'b0, 1'b1, st);
    idle_bits(1);
    check("after reset data_valid", dv_cnt - dv0, 1);
    check("after reset data_out", int'(data_out), 8'h3C);

`ifdef UART_RX_PARITY_EN
    dv0 = dv_cnt;
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1, st);
    idle_bits(1);
    check("parity ok data_valid", dv_cnt - dv0, 1);
    check("parity ok parity_err", pe_cnt - pe0, 0);
    dv0 = dv_cnt;
    send_frame(8'h07, 1'b0, 1'b1, st);
    idle_bits(1);
    check("parity bad data_valid", dv_cnt - dv0, 1);
    check("parity bad parity_err", pe_cnt - pe0, 1);
    check("parity bad data_out", int'(data_out), 8'h07);
    fe0 = fe_cnt;
    send_frame(8'h07, 1'b0, 1'b0, st);
    idle_bits(1);
    check("parity framing suppresses parity_err", pe_cnt - pe0, 1);
    check("parity framing_err", fe_cnt - fe0, 1);
`else
    pe0 = pe_cnt;
    check("no parity pulses", pe_cnt - pe0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
